// File: rtl/echo_tof_timer_pkg.sv
// Shared definitions for the echo time-of-flight timer: FSM encoding and
// default sizing constants.
package echo_tof_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BLANK   = 2'd1,
    ST_LISTEN  = 2'd2,
    ST_CONFIRM = 2'd3
  } state_e;

  localparam int CNT_W_DEF = 32;
  localparam int DEB_N_DEF = 4;

  // Wide enough for the largest supported run length (15).
  localparam int DEB_W = 4;

endpackage

// File: rtl/echo_tof_timer_debounce.sv
// Run-length counter that confirms an echo once DEB_N consecutive tick
// samples of the comparator are high.
module tof_debounce
  import echo_tof_timer_pkg::*;
#(
  parameter int DEB_N = DEB_N_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic cmp_i,
  input  logic arm_i,
  input  logic run_i,
  output logic match_o,
  output logic fail_o
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_N - 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_N);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

  logic [DEB_W-1:0] deb_q;
  logic [DEB_W-1:0] deb_d;
  logic             single_hit;

  assign single_hit = (DEB_N == 1);

  always_comb begin
    deb_d = deb_q;
    if (!(arm_i || run_i)) begin
      deb_d = '0;
    end else if (tick_i) begin
      if (arm_i && cmp_i) begin
        deb_d = DEB_ONE;
      end else if (run_i && cmp_i && (deb_q != DEB_MAX)) begin
        deb_d = deb_q + DEB_ONE;
      end else if (run_i && !cmp_i) begin
        deb_d = '0;
      end
    end
  end

  // The confirming tick is detected before deb itself is updated.
  assign match_o = tick_i && cmp_i &&
                   ((arm_i && single_hit) || (run_i && (deb_q == DEB_LAST)));
  assign fail_o  = run_i && tick_i && !cmp_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= '0;
    end else begin
      deb_q <= deb_d;
    end
  end

endmodule

// File: rtl/echo_tof_timer.sv
// Ultrasonic echo time-of-flight timer: blanking, debounced echo detection,
// timeout, abort and a sticky completion interrupt.
module echo_tof_timer
  import echo_tof_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEB_N = DEB_N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cmp_i,
  input  logic [CNT_W-1:0] blank_i,
  input  logic [CNT_W-1:0] timeout_i,
  input  logic             irq_clr_i,
  output logic [CNT_W-1:0] tof_o,
  output logic             tof_valid_o,
  output logic             timeout_o,
  output logic             busy_o,
  output logic             irq_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] tof_q, tof_d;
  logic             tof_valid_q, tof_valid_d;
  logic             timeout_q, timeout_d;
  logic             irq_q, irq_d;

  logic             busy;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit_timeout;
  logic             echo_done;
  logic             deb_fail;

  assign busy        = (state_q != ST_IDLE);
  // Saturate rather than wrap so a huge timeout can never alias a short one.
  assign cnt_inc     = (&cnt_q) ? cnt_q : (cnt_q + CNT_ONE);
  assign hit_timeout = busy && tick_i && (cnt_inc >= timeout_i);

  tof_debounce #(
    .DEB_N (DEB_N)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .tick_i  (tick_i),
    .cmp_i   (cmp_i),
    .arm_i   (state_q == ST_LISTEN),
    .run_i   (state_q == ST_CONFIRM),
    .match_o (echo_done),
    .fail_o  (deb_fail)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    tof_d       = tof_q;
    tof_valid_d = tof_valid_q;
    timeout_d   = timeout_q;
    irq_d       = irq_q && !irq_clr_i;

    if (busy && abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i && !abort_i) begin
            state_d     = ST_BLANK;
            cnt_d       = '0;
            tof_valid_d = 1'b0;
            timeout_d   = 1'b0;
          end
        end
        ST_BLANK: begin
          if ((cnt_q >= blank_i) || (tick_i && (cnt_inc >= blank_i))) begin
            state_d = ST_LISTEN;
          end
        end
        ST_LISTEN: begin
          if (tick_i && cmp_i) begin
            cand_d  = cnt_q;
            state_d = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (deb_fail) begin
            state_d = ST_LISTEN;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (busy && tick_i) begin
        cnt_d = cnt_inc;
      end

      // Echo beats a timeout landing on the same tick.
      if (echo_done) begin
        state_d     = ST_IDLE;
        tof_d       = (state_q == ST_LISTEN) ? cnt_q : cand_q;
        tof_valid_d = 1'b1;
        irq_d       = 1'b1;
      end else if (hit_timeout) begin
        state_d   = ST_IDLE;
        timeout_d = 1'b1;
        irq_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      tof_q       <= '0;
      tof_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      tof_q       <= tof_d;
      tof_valid_q <= tof_valid_d;
      timeout_q   <= timeout_d;
      irq_q       <= irq_d;
    end
  end

  assign tof_o       = tof_q;
  assign tof_valid_o = tof_valid_q;
  assign timeout_o   = timeout_q;
  assign busy_o      = busy;
  assign irq_o       = irq_q;

endmodule
